// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: 256x16 data memory, three-cycle stalled loads, one-cycle ALU writeback.
// Optional forwarding tap enabled by defining MEMWB_FWD_EN; otherwise the fwd_* outputs are tied to zero.
module mem_wb_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_store_data,
  input  logic [1:0]  ex_wr,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  output logic        stall,
  output logic        wb_regwrite,
  output logic [1:0]  wb_wr,
  output logic [15:0] wb_wd,
  output logic        fwd_valid,
  output logic [1:0]  fwd_wr,
  output logic [15:0] fwd_data
);

  typedef enum logic [1:0] {IDLE, LOAD1, LOAD2, WB} state_t;

  state_t      state_q, state_d;
  logic [15:0] mem [256];
  logic [7:0]  load_idx_q;
  logic [1:0]  load_wr_q;
  logic        wb_we_q;
  logic [1:0]  wb_wr_q;
  logic [15:0] wb_wd_q;
  logic        accepting, is_load, is_store;

  // WB retires the previous load and can accept a new instruction in the same cycle.
  assign accepting = ex_valid && (state_q == IDLE || state_q == WB);
  assign is_load   = accepting && ex_memread;
  assign is_store  = accepting && ex_memwrite && !ex_memread;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, WB: state_d = is_load ? LOAD1 : IDLE;
      LOAD1:    state_d = LOAD2;
      LOAD2:    state_d = WB;
      default:  state_d = IDLE;
    endcase
  end

  // Gated by reset_n so an aborted load releases upstream immediately.
  assign stall = reset_n && (is_load || state_q == LOAD1 || state_q == LOAD2);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      load_idx_q <= '0;
      load_wr_q  <= '0;
      wb_we_q    <= 1'b0;
      wb_wr_q    <= '0;
      wb_wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wb_we_q <= 1'b0;
      if (state_q == LOAD2) begin
        wb_we_q <= 1'b1;
        wb_wr_q <= load_wr_q;
        wb_wd_q <= mem[load_idx_q];
      end else if (is_load) begin
        load_idx_q <= ex_alu_out[8:1];
        load_wr_q  <= ex_wr;
      end else if (accepting) begin
        wb_we_q <= ex_regwrite && !ex_memwrite;
        wb_wr_q <= ex_wr;
        wb_wd_q <= ex_alu_out;
      end
    end
  end

  // NOTE: the memory array has no reset; its contents must survive reset_n.
  always_ff @(negedge clock) begin
    if (is_store) mem[ex_alu_out[8:1]] <= ex_store_data;
  end

  assign wb_regwrite = wb_we_q && (wb_wr_q != 2'd0);
  assign wb_wr       = wb_wr_q;
  assign wb_wd       = wb_wd_q;

`ifdef MEMWB_FWD_EN
  // Suppress the tap while stalled so a consumer never picks up stale data.
  assign fwd_valid = wb_regwrite && !stall;
  assign fwd_wr    = wb_wr_q;
  assign fwd_data  = wb_wd_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_wr    = 2'd0;
  assign fwd_data  = 16'd0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected writebacks are queued with their due cycle.
// Inputs change just after the falling (active) edge; outputs are sampled on the rising edge.
module tb_mem_wb_stage;

  logic        clock, reset_n;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [15:0] ex_alu_out, ex_store_data;
  logic [1:0]  ex_wr;
  logic        stall, wb_regwrite, fwd_valid;
  logic [1:0]  wb_wr, fwd_wr;
  logic [15:0] wb_wd, fwd_data;

  mem_wb_stage dut (
    .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .ex_wr(ex_wr), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .stall(stall),
    .wb_regwrite(wb_regwrite), .wb_wr(wb_wr), .wb_wd(wb_wd),
    .fwd_valid(fwd_valid), .fwd_wr(fwd_wr), .fwd_data(fwd_data)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  wr;
    logic [15:0] wd;
  } wb_exp_t;

  wb_exp_t     sb[$];
  logic [15:0] tb_mem [256];
  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc      = 0;
  logic        mon_en   = 1'b0;
  logic        exp_stall_now = 1'b0;
  logic        mon_fwd_exp;
  wb_exp_t     mon_e;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(negedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each writeback and checks timing, data and the forwarding tap.
  always @(posedge clock) begin
    if (mon_en) begin
      mon_fwd_exp = 1'b0;
      if (wb_regwrite) begin
        if (sb.size() == 0) begin
          check("spurious_wb", {31'd0, wb_regwrite}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("wb_cycle", cyc, mon_e.cyc);
          check("wb_wr", {30'd0, wb_wr}, {30'd0, mon_e.wr});
          check("wb_wd", {16'd0, wb_wd}, {16'd0, mon_e.wd});
          mon_fwd_exp = !exp_stall_now;
`ifdef MEMWB_FWD_EN
          check("fwd_wr", {30'd0, fwd_wr}, {30'd0, mon_e.wr});
          check("fwd_data", {16'd0, fwd_data}, {16'd0, mon_e.wd});
`endif
        end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
        void'(sb.pop_front());
        check("wb_missing", {31'd0, wb_regwrite}, 32'd1);
      end
`ifdef MEMWB_FWD_EN
      check("fwd_valid", {31'd0, fwd_valid}, {31'd0, mon_fwd_exp});
`else
      check("fwd_valid_tied", {31'd0, fwd_valid}, 32'd0);
      check("fwd_wr_tied", {30'd0, fwd_wr}, 32'd0);
      check("fwd_data_tied", {16'd0, fwd_data}, 32'd0);
`endif
    end
  end

  // One pipeline cycle of stimulus; lat != 0 queues a writeback due lat cycles later.
  task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                       input logic [1:0] wr, input logic [15:0] alu, input logic [15:0] sd,
                       input logic exp_stall, input int lat, input logic [15:0] wd);
    @(negedge clock);
    #1;
    ex_valid = v; ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw;
    ex_wr = wr; ex_alu_out = alu; ex_store_data = sd;
    exp_stall_now = exp_stall;
    if (lat != 0) sb.push_back('{cyc + lat, wr, wd});
    @(posedge clock);
    check("stall", {31'd0, stall}, {31'd0, exp_stall});
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 0, 16'h0);
  endtask

  task automatic alu_op(input logic [1:0] wr, input logic [15:0] val);
    drive(1'b1, 1'b1, 1'b0, 1'b0, wr, val, 16'h0, 1'b0, (wr != 2'd0) ? 1 : 0, val);
  endtask

  task automatic store(input logic [15:0] addr, input logic [15:0] data);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, addr, data, 1'b0, 0, 16'h0);
    tb_mem[addr[8:1]] = data;
  endtask

  // Load; mw also raises memwrite (store must be dropped); garbage changes inputs during LOAD1/LOAD2.
  task automatic load(input logic [15:0] addr, input logic [1:0] wr, input logic mw, input logic garbage);
    logic [15:0] exp;
    exp = tb_mem[addr[8:1]];
    drive(1'b1, 1'b1, 1'b1, mw, wr, addr, 16'hAAAA, 1'b1, (wr != 2'd0) ? 3 : 0, exp);
    for (int i = 0; i < 2; i++) begin
      if (garbage) drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0020, 16'hDEAD, 1'b1, 0, 16'h0);
      else         drive(1'b1, 1'b1, 1'b1, mw, wr, addr, 16'hAAAA, 1'b1, 0, 16'h0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_wb_regwrite"}, {31'd0, wb_regwrite}, 32'd0);
    check({tag, "_wb_wr"}, {30'd0, wb_wr}, 32'd0);
    check({tag, "_wb_wd"}, {16'd0, wb_wd}, 32'd0);
    check({tag, "_fwd_valid"}, {31'd0, fwd_valid}, 32'd0);
    check({tag, "_fwd_wr"}, {30'd0, fwd_wr}, 32'd0);
    check({tag, "_fwd_data"}, {16'd0, fwd_data}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    ex_valid = 1'b0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_wr = 2'd0; ex_alu_out = 16'h0; ex_store_data = 16'h0;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(negedge clock);
    #3 reset_n = 1'b1;
    mon_en = 1'b1;

    // ALU results, register-0 suppression, bubble
    alu_op(2'd1, 16'h000F);
    alu_op(2'd2, 16'h0007);
    alu_op(2'd0, 16'h0007);
    bubble();

    store(16'h0010, 16'h1234);
    store(16'h0200, 16'hBEEF);
    store(16'h0020, 16'h5555);
    store(16'h0030, 16'h1111);

    // Inputs ignored during LOAD1/LOAD2; then back-to-back load accepted in WB with wrap-around
    load(16'h0010, 2'd2, 1'b0, 1'b1);
    load(16'h0000, 2'd1, 1'b0, 1'b0);
    alu_op(2'd3, 16'hABCD);
    load(16'h0030, 2'd1, 1'b1, 1'b0);
    load(16'h0020, 2'd3, 1'b0, 1'b0);
    load(16'h0030, 2'd1, 1'b0, 1'b0);
    bubble();
    bubble();

    // Reset asserted during LOAD2 aborts the load; memory survives
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 16'h0010, 16'h0, 1'b1, 0, 16'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 16'h0010, 16'h0, 1'b1, 0, 16'h0);
    @(negedge clock);
    #2;
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    ex_valid = 1'b0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    exp_stall_now = 1'b0;
    repeat (2) @(negedge clock);
    #3 reset_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) bubble();
    load(16'h0010, 2'd2, 1'b0, 1'b0);

    repeat (5) bubble();
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
